fifo_wr_arbiter: RTL

- Round-robin write-side scheduler that shares one fifo_fwft write port between NUM_REQ producers.
- Each producer uses a valid/ready interface with a last marker.
- The block grants one producer at a time and holds the grant for a burst, which ends on last or after MAX_BURST beats.
- It tracks FIFO occupancy with a credit counter so registered writes never overflow. It sits directly in front of fifo_fwft wen_i/wdata_i.

---
 rtl/fifo_wr_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin scheduler sharing one fifo_fwft write port between NUM_REQ valid/ready producers.
// Grants are held per burst (last or MAX_BURST beats); a credit counter keeps registered writes from overflowing.
module fifo_wr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int FIFO_DEPTH = 8,
   parameter int MAX_BURST  = 4,
   parameter int CRED_WIDTH = $clog2(FIFO_DEPTH + 1)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req_valid_i,
   input  logic [NUM_REQ-1:0]            req_last_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
   output logic [NUM_REQ-1:0]            req_ready_o,
   input  logic                          fifo_ren_i,
   output logic                          fifo_wen_o,
   output logic [DATA_WIDTH-1:0]         fifo_wdata_o,
   output logic [NUM_REQ-1:0]            grant_o,
   output logic [CRED_WIDTH-1:0]         credit_o
);
   localparam int IDX_W  = $clog2(NUM_REQ);
   localparam int BEAT_W = $clog2(MAX_BURST + 1);
   localparam logic [CRED_WIDTH-1:0] CRED_FULL = CRED_WIDTH'(FIFO_DEPTH);
   localparam logic [BEAT_W-1:0]     BEAT_LAST = BEAT_W'(MAX_BURST - 1);
   localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_REQ - 1);

   typedef enum logic {IDLE, BURST} state_e;

   state_e                 state_q, state_d;
   logic [NUM_REQ-1:0]     grant_q, grant_d;
   logic [IDX_W-1:0]       gidx_q, gidx_d;
   logic [IDX_W-1:0]       ptr_q, ptr_d;
   logic [BEAT_W-1:0]      beat_q, beat_d;
   logic [CRED_WIDTH-1:0]  credit_q, credit_d;
   logic                   wen_q, wen_d;
   logic [DATA_WIDTH-1:0]  wdata_q, wdata_d;

   logic                   accept;
   logic                   pop_ok;
   logic                   found;
   logic [IDX_W-1:0]       pick;
   logic [IDX_W-1:0]       cand;

   assign req_ready_o = (state_q == BURST && credit_q != '0) ? grant_q : '0;
   assign accept      = |(req_valid_i & req_ready_o);
   assign pop_ok      = fifo_ren_i && (credit_q != CRED_FULL);

   // First valid requester at or after the pointer, wrapping modulo NUM_REQ.
   always_comb begin
      // NOTE: every variable assigned here gets a default first, so no path can infer a latch.
      pick  = '0;
      found = 1'b0;
      cand  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         cand = (int'(ptr_q) + i >= NUM_REQ) ? IDX_W'(int'(ptr_q) + i - NUM_REQ)
                                             : IDX_W'(int'(ptr_q) + i);
         if (!found && req_valid_i[cand]) begin
            found = 1'b1;
            pick  = cand;
         end
      end
   end

   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      gidx_d   = gidx_q;
      ptr_d    = ptr_q;
      beat_d   = beat_q;
      wen_d    = accept;
      wdata_d  = wdata_q;
      credit_d = credit_q;

      if (pop_ok && !accept) begin
         credit_d = credit_q + 1'b1;
      end else if (accept && !pop_ok) begin
         credit_d = credit_q - 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (found) begin
               state_d = BURST;
               grant_d = NUM_REQ'(1) << pick;
               gidx_d  = pick;
            end
         end
         BURST: begin
            if (accept) begin
               wdata_d = req_data_i[int'(gidx_q) * DATA_WIDTH +: DATA_WIDTH];
               beat_d  = beat_q + 1'b1;
               // Burst ends on last or on the MAX_BURST-th beat; the owner drops to lowest priority.
               if (req_last_i[gidx_q] || beat_q == BEAT_LAST) begin
                  state_d = IDLE;
                  grant_d = '0;
                  beat_d  = '0;
                  ptr_d   = (gidx_q == IDX_LAST) ? '0 : gidx_q + 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         grant_q  <= '0;
         gidx_q   <= '0;
         ptr_q    <= '0;
         beat_q   <= '0;
         credit_q <= CRED_FULL;
         wen_q    <= 1'b0;
         wdata_q  <= '0;
      end else begin
         // NOTE: flops take only non-blocking assignments; all next-state math lives in the comb blocks.
         state_q  <= state_d;
         grant_q  <= grant_d;
         gidx_q   <= gidx_d;
         ptr_q    <= ptr_d;
         beat_q   <= beat_d;
         credit_q <= credit_d;
         wen_q    <= wen_d;
         wdata_q  <= wdata_d;
      end
   end

   assign grant_o      = grant_q;
   assign fifo_wen_o   = wen_q;
   assign fifo_wdata_o = wdata_q;
   assign credit_o     = credit_q;

   a_grant_onehot: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(grant_q));
   a_credit_bound: assert property (@(posedge clk) disable iff (!rst_n) credit_q <= CRED_FULL);
   a_pop_nonempty: assert property (@(posedge clk) disable iff (!rst_n) fifo_ren_i |-> credit_q != CRED_FULL);

endmodule
